// File: rtl/mii_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mii_tx_arbiter_if : request/nibble/grant bundle between frame sources and
//                     the shared MII transmit arbiter.
// Revision: 1.0
// ============================================================================
interface mii_tx_arbiter_if #(
    parameter int N_REQ = 2
) ();
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] in_d;
    logic [N_REQ-1:0]   in_dv;
    logic [N_REQ-1:0]   gnt;
    logic [2:0]         gnt_idx;
    logic [3:0]         tx_d;
    logic               tx_dv;
    logic               busy;
    logic               abort;
    logic               timeout;

    modport master (
        output req, in_d, in_dv,
        input  gnt, gnt_idx, tx_d, tx_dv, busy, abort, timeout
    );

    modport slave (
        input  req, in_d, in_dv,
        output gnt, gnt_idx, tx_d, tx_dv, busy, abort, timeout
    );
endinterface

`default_nettype wire

// File: rtl/mii_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mii_tx_arbiter : round-robin whole-frame arbiter for the shared MII TX nibble
//                  path, with inter-frame gap, start timeout and length cap.
// Revision: 1.0
// ============================================================================
module mii_tx_arbiter #(
    parameter int N_REQ         = 2,
    parameter int IFG_NIBBLES   = 24,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_NIBBLES   = 3036
) (
    input wire              clk,
    input wire              reset_n,
    mii_tx_arbiter_if.slave bus
);

    localparam int NCNT_W = $clog2(MAX_NIBBLES + 1);
    localparam int TCNT_W = $clog2(START_TIMEOUT + 1);
    localparam int GCNT_W = $clog2(IFG_NIBBLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_PASS  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [N_REQ-1:0]   gnt_q,     gnt_d;
    logic [2:0]         gnt_idx_q, gnt_idx_d;
    logic [2:0]         ptr_q,     ptr_d;
    logic [3:0]         tx_d_q,    tx_d_d;
    logic               tx_dv_q,   tx_dv_d;
    logic               abort_q,   abort_d;
    logic               timeout_q, timeout_d;
    logic [NCNT_W-1:0]  ncnt_q,    ncnt_d;
    logic [TCNT_W-1:0]  tcnt_q,    tcnt_d;
    logic [GCNT_W-1:0]  gcnt_q,    gcnt_d;

    logic               sel_dv;
    logic               sel_req;
    logic [3:0]         sel_d;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [3:0]         cand;

    // Grantee's lane, selected by the registered grant index.
    always_comb begin
        sel_dv  = 1'b0;
        sel_req = 1'b0;
        sel_d   = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx_q == 3'(i)) begin
                sel_dv  = bus.in_dv[i];
                sel_req = bus.req[i];
                sel_d   = bus.in_d[4*i +: 4];
            end
        end
    end

    // Round-robin search starting at the pointer, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!win_found && cand == 4'(j) && bus.req[j]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        tx_d_d    = tx_d_q;
        tx_dv_d   = tx_dv_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        ncnt_d    = ncnt_q;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;

        case (state_q)
            S_IDLE: begin
                tx_d_d  = 4'd0;
                tx_dv_d = 1'b0;
                if (win_found) begin
                    state_d   = S_GRANT;
                    gnt_idx_d = win_idx;
                    tcnt_d    = '0;
                    gnt_d     = '0;
                    for (int j = 0; j < N_REQ; j++) begin
                        if (win_idx == 3'(j)) begin
                            gnt_d[j] = 1'b1;
                        end
                    end
                    // Pointer moves past the winner now, so every exit from
                    // GRANT (start, abandon or timeout) leaves it advanced.
                    if (win_idx == 3'(N_REQ - 1)) begin
                        ptr_d = 3'd0;
                    end else begin
                        ptr_d = win_idx + 3'd1;
                    end
                end
            end

            S_GRANT: begin
                if (sel_dv) begin
                    state_d = S_PASS;
                    tx_d_d  = sel_d;
                    tx_dv_d = 1'b1;
                    ncnt_d  = NCNT_W'(1);
                end else if (!sel_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (tcnt_q >= TCNT_W'(START_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            S_PASS: begin
                if (!sel_dv) begin
                    state_d = S_GAP;
                    tx_d_d  = 4'd0;
                    tx_dv_d = 1'b0;
                    gnt_d   = '0;
                    gcnt_d  = '0;
                end else if (ncnt_q >= NCNT_W'(MAX_NIBBLES)) begin
                    state_d = S_DRAIN;
                    tx_d_d  = 4'd0;
                    tx_dv_d = 1'b0;
                    abort_d = 1'b1;
                end else begin
                    tx_d_d  = sel_d;
                    tx_dv_d = 1'b1;
                    ncnt_d  = ncnt_q + NCNT_W'(1);
                end
            end

            S_DRAIN: begin
                tx_d_d  = 4'd0;
                tx_dv_d = 1'b0;
                if (!sel_dv) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    gcnt_d  = '0;
                end
            end

            S_GAP: begin
                tx_d_d  = 4'd0;
                tx_dv_d = 1'b0;
                if (gcnt_q >= GCNT_W'(IFG_NIBBLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                tx_d_d  = 4'd0;
                tx_dv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= 3'd0;
            ptr_q     <= 3'd0;
            tx_d_q    <= 4'd0;
            tx_dv_q   <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
            ncnt_q    <= '0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            tx_d_q    <= tx_d_d;
            tx_dv_q   <= tx_dv_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
            ncnt_q    <= ncnt_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.tx_d    = tx_d_q;
    assign bus.tx_dv   = tx_dv_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.abort   = abort_q;
    assign bus.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mii_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mii_tx_arbiter : scoreboard bench; source tasks queue expected frames,
//                     a negedge monitor checks grants, nibbles, gaps, pulses.
// Revision: 1.0
// ============================================================================
module tb_mii_tx_arbiter;

    localparam int N_REQ = 2;
    localparam int IFG   = 24;
    localparam int TOUT  = 16;
    localparam int MAXN  = 3036;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mii_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    mii_tx_arbiter #(
        .N_REQ        (N_REQ),
        .IFG_NIBBLES  (IFG),
        .START_TIMEOUT(TOUT),
        .MAX_NIBBLES  (MAXN)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic       src_req [N_REQ];
    logic       src_dv  [N_REQ];
    logic [3:0] src_d   [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            bus.req[i]         = src_req[i];
            bus.in_dv[i]       = src_dv[i];
            bus.in_d[4*i +: 4] = src_d[i];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [3:0] exp_nib   [$];
    int         exp_len   [$];
    int         exp_start [$];
    bit         exp_abt   [$];
    int exp_timeouts = 0, seen_timeouts = 0;
    int exp_aborts   = 0, seen_aborts   = 0;
    int n_cmp = 0, n_fail = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_gnt(input int s, output bit got);
        int waited = 0;
        while (bus.gnt[s] !== 1'b1 && waited < 8000) begin
            @(posedge clk); #1; waited++;
        end
        got = (bus.gnt[s] === 1'b1);
    endtask

    // One frame from source s; rst_at>0 pulses reset alongside that nibble.
    task automatic send_frame(input int s, input int len, input int dly, input int rst_at);
        logic [3:0] nib [$];
        int  n_out;
        bit  got;
        src_req[s] = 1'b1;
        wait_gnt(s, got);
        if (!got) begin
            check(1'b0, "grant_wait", 0, 1);
            src_req[s] = 1'b0;
            return;
        end
        idle(dly);
        for (int k = 0; k < len; k++) nib.push_back(4'($urandom));
        n_out = (rst_at > 0) ? rst_at - 1 : ((len > MAXN) ? MAXN : len);
        for (int k = 0; k < n_out; k++) exp_nib.push_back(nib[k]);
        exp_len.push_back(n_out);
        exp_start.push_back(cyc);
        exp_abt.push_back(rst_at == 0 && len > MAXN);
        if (rst_at == 0 && len > MAXN) exp_aborts++;
        for (int k = 0; k < len; k++) begin
            src_dv[s] = 1'b1;
            src_d[s]  = nib[k];
            if (k + 1 == rst_at) reset_n = 1'b0;
            @(posedge clk); #1;
            if (!reset_n) begin
                reset_n = 1'b1;
                break;
            end
        end
        src_dv[s]  = 1'b0;
        src_d[s]   = 4'($urandom);
        src_req[s] = 1'b0;
    endtask

    // Granted but never starts: either waits out the timeout or drops req.
    task automatic no_start(input int s, input bit abandon);
        bit got;
        int waited = 0;
        src_req[s] = 1'b1;
        wait_gnt(s, got);
        if (!got) begin
            check(1'b0, "grant_wait_ns", 0, 1);
            src_req[s] = 1'b0;
            return;
        end
        if (abandon) begin
            idle(3);
            src_req[s] = 1'b0;
            idle(3);
            return;
        end
        exp_timeouts++;
        while (bus.gnt[s] === 1'b1 && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        check(bus.gnt[s] === 1'b0, "timeout_revoke", bus.gnt[s], 0);
        src_req[s] = 1'b0;
    endtask

    task automatic source_run(input int s, input int nfr);
        for (int f = 0; f < nfr; f++) begin
            idle($urandom_range(2, 12));
            send_frame(s, $urandom_range(1, 40), $urandom_range(0, 4), 0);
        end
    endtask

    // Monitor
    bit               rst_pend = 1'b0, in_run = 1'b0, had_data = 1'b0, have_fall = 1'b0;
    logic [N_REQ-1:0] gnt_prev = '0, req_prev = '0;
    logic             busy_prev = 1'b0;
    int last_g = N_REQ - 1;
    int run_cnt = 0, run_len_exp = 0, gnt_rise_cyc = 0, gnt_fall_cyc = 0, fall_cyc = 0;
    int e_win, j_idx, st;
    bit run_abt_exp = 1'b0;
    logic [3:0]  en;
    logic [31:0] rs;

    always @(negedge clk) begin
        if (rst_pend) begin
            rs = 32'({bus.gnt, bus.gnt_idx, bus.tx_d, bus.tx_dv, bus.busy, bus.abort, bus.timeout});
            check(rs == 32'd0, "reset_state", rs, 0);
            if (in_run) check(run_cnt == run_len_exp, "frame_len_reset", run_cnt, run_len_exp);
            in_run    = 1'b0;
            had_data  = 1'b0;
            have_fall = 1'b0;
            last_g    = N_REQ - 1;
        end else begin
            if (bus.gnt != '0 && gnt_prev == '0) begin
                e_win = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    j_idx = (last_g + k) % N_REQ;
                    if (e_win < 0 && req_prev[j_idx]) e_win = j_idx;
                end
                check(e_win >= 0 && bus.gnt == N_REQ'(1 << e_win) && int'(bus.gnt_idx) == e_win,
                      "rr_grant", bus.gnt_idx, e_win);
                if (e_win >= 0) last_g = e_win;
                gnt_rise_cyc = cyc;
            end
            if (bus.gnt == '0 && gnt_prev != '0) gnt_fall_cyc = cyc;

            check($countones(bus.gnt) <= 1 && !(bus.tx_dv && !bus.busy), "onehot_busy",
                  bus.gnt, 0);

            if (bus.timeout) begin
                seen_timeouts++;
                check(cyc - gnt_rise_cyc == TOUT && bus.gnt == '0, "timeout_timing",
                      cyc - gnt_rise_cyc, TOUT);
            end

            if (bus.tx_dv) begin
                if (!in_run) begin
                    in_run   = 1'b1;
                    had_data = 1'b1;
                    run_cnt  = 0;
                    if (exp_len.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                        run_len_exp = 0;
                        run_abt_exp = 1'b0;
                    end else begin
                        run_len_exp = exp_len.pop_front();
                        run_abt_exp = exp_abt.pop_front();
                        st          = exp_start.pop_front();
                        check(cyc == st + 1, "latency", cyc - st, 1);
                    end
                    if (have_fall) check(cyc - fall_cyc >= IFG, "ifg_min", cyc - fall_cyc, IFG);
                end
                run_cnt++;
                if (bus.abort) check(1'b0, "abort_during_dv", 1, 0);
                if (run_cnt > run_len_exp || exp_nib.size() == 0) begin
                    check(1'b0, "nibble_extra", run_cnt, run_len_exp);
                end else begin
                    en = exp_nib.pop_front();
                    check(bus.tx_d == en, "nibble", bus.tx_d, en);
                end
            end else begin
                check(bus.tx_d == 4'd0, "tx_d_idle", bus.tx_d, 0);
                if (in_run) begin
                    in_run    = 1'b0;
                    have_fall = 1'b1;
                    fall_cyc  = cyc;
                    check(run_cnt == run_len_exp, "frame_len", run_cnt, run_len_exp);
                    check(bus.abort == run_abt_exp, "abort_at_end", bus.abort, run_abt_exp);
                    if (bus.abort) seen_aborts++;
                end else if (bus.abort) begin
                    check(1'b0, "abort_spurious", 1, 0);
                end
            end

            if (busy_prev && !bus.busy) begin
                if (had_data) check(cyc - gnt_fall_cyc == IFG, "gap_len", cyc - gnt_fall_cyc, IFG);
                else          check(cyc == gnt_fall_cyc, "no_gap", cyc - gnt_fall_cyc, 0);
                had_data = 1'b0;
            end
        end
        gnt_prev  = bus.gnt;
        req_prev  = bus.req;
        busy_prev = bus.busy;
        rst_pend  = !reset_n;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int waited;
        for (int i = 0; i < N_REQ; i++) begin
            src_req[i] = 1'b0;
            src_dv[i]  = 1'b0;
            src_d[i]   = 4'd0;
        end
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // Single long frame from source 0
        send_frame(0, 120, 0, 0);
        idle(40);

        // Both sources competing
        fork
            source_run(0, 4);
            source_run(1, 4);
        join
        idle(40);

        // Start timeout on source 0, source 1 waiting behind it
        fork
            no_start(0, 1'b0);
            begin idle(2); send_frame(1, 8, 0, 0); end
        join
        idle(40);

        // Grantee drops req before starting
        no_start(0, 1'b1);
        idle(10);

        // Over-length frame gets truncated
        send_frame(0, 3100, 1, 0);
        idle(40);

        // Reset in the middle of a frame, then both request together
        send_frame(0, 120, 0, 50);
        idle(3);
        fork
            send_frame(0, 10, 0, 0);
            send_frame(1, 10, 0, 0);
        join
        idle(40);

        // Non-grantee request chatter during a frame
        fork
            send_frame(0, 60, 0, 0);
            begin
                waited = 0;
                while (!bus.tx_dv && waited < 200) begin idle(1); waited++; end
                check(bus.tx_dv === 1'b1, "chatter_start", bus.tx_dv, 1);
                for (int k = 0; k < 20; k++) begin
                    src_req[1] = 1'($urandom);
                    idle(1);
                end
                src_req[1] = 1'b0;
                idle(1);
                send_frame(1, 10, 0, 0);
            end
        join
        idle(40);

        // Randomized traffic
        fork
            source_run(0, 8);
            source_run(1, 8);
        join
        idle(60);

        check(exp_nib.size() == 0 && exp_len.size() == 0, "scoreboard_empty", exp_len.size(), 0);
        check(seen_timeouts == exp_timeouts, "timeout_count", seen_timeouts, exp_timeouts);
        check(seen_aborts == exp_aborts, "abort_count", seen_aborts, exp_aborts);
        ok = (bus.busy === 1'b0);
        check(ok, "final_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
